// File: rtl/cic_decim_iq.sv
// Two-channel (I/Q) CIC decimator: per-channel integrator cascade, strobed comb pipeline,
// truncating output scaler, small output FIFO with DATA_RDY/DATA_ACK readout and sticky overflow.
module cic_decim_iq #(
   parameter int STAGES     = 3,
   parameter int DECIM      = 64,
   parameter int IN_W       = 12,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    CIC_CLK,
   input  logic                    RST_N,
   input  logic signed [IN_W-1:0]  IN_I,
   input  logic signed [IN_W-1:0]  IN_Q,
   input  logic                    IN_VALID,
   output logic signed [OUT_W-1:0] OUT_I,
   output logic signed [OUT_W-1:0] OUT_Q,
   output logic                    DATA_RDY,
   input  logic                    DATA_ACK,
   output logic                    OVF,
   input  logic                    OVF_CLR
);

   localparam int CNT_W = $clog2(DECIM);
   localparam int ACC_W = IN_W + STAGES * CNT_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [OUT_W-1:0] out_t;

   // Keep the top OUT_W bits; the arithmetic shift floors toward negative infinity.
   function automatic out_t scale(input acc_t x);
      acc_t shifted;
      shifted = x >>> (ACC_W - OUT_W);
      return out_t'(shifted);
   endfunction

   acc_t integ_i_q [STAGES];
   acc_t integ_i_d [STAGES];
   acc_t integ_q_q [STAGES];
   acc_t integ_q_d [STAGES];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             strobe;

   logic [STAGES:0]  stb_q, stb_d;

   acc_t comb_i_q [STAGES];
   acc_t comb_i_d [STAGES];
   acc_t comb_q_q [STAGES];
   acc_t comb_q_d [STAGES];
   acc_t dly_i_q  [STAGES];
   acc_t dly_i_d  [STAGES];
   acc_t dly_q_q  [STAGES];
   acc_t dly_q_d  [STAGES];
   acc_t comb_in_i [STAGES];
   acc_t comb_in_q [STAGES];

   out_t fifo_i_q [FIFO_DEPTH];
   out_t fifo_i_d [FIFO_DEPTH];
   out_t fifo_q_q [FIFO_DEPTH];
   out_t fifo_q_d [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   out_t             out_i_q, out_i_d;
   out_t             out_q_q, out_q_d;
   logic             ovf_q, ovf_d;

   logic             wr_req, pop, full, wr_en, ovf_evt, land_at_head;
   out_t             wr_i, wr_q;

   // ---------------- integrators and decimation counter ----------------
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         integ_i_d[k] = integ_i_q[k];
         integ_q_d[k] = integ_q_q[k];
      end
      cnt_d  = cnt_q;
      strobe = 1'b0;
      if (IN_VALID) begin
         integ_i_d[0] = integ_i_q[0] + acc_t'(IN_I);
         integ_q_d[0] = integ_q_q[0] + acc_t'(IN_Q);
         for (int k = 1; k < STAGES; k++) begin
            integ_i_d[k] = integ_i_q[k] + integ_i_q[k-1];
            integ_q_d[k] = integ_q_q[k] + integ_q_q[k-1];
         end
         strobe = (cnt_q == CNT_LAST);
         cnt_d  = strobe ? '0 : cnt_q + 1'b1;
      end
   end

   // ---------------- comb pipeline, one stage per edge after the strobe ----------------
   always_comb begin
      comb_in_i[0] = integ_i_q[STAGES-1];
      comb_in_q[0] = integ_q_q[STAGES-1];
      for (int k = 1; k < STAGES; k++) begin
         comb_in_i[k] = comb_i_q[k-1];
         comb_in_q[k] = comb_q_q[k-1];
      end
   end

   always_comb begin
      stb_d[0] = strobe;
      for (int k = 1; k <= STAGES; k++) begin
         stb_d[k] = stb_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         comb_i_d[k] = comb_i_q[k];
         comb_q_d[k] = comb_q_q[k];
         dly_i_d[k]  = dly_i_q[k];
         dly_q_d[k]  = dly_q_q[k];
         if (stb_q[k]) begin
            comb_i_d[k] = comb_in_i[k] - dly_i_q[k];
            comb_q_d[k] = comb_in_q[k] - dly_q_q[k];
            dly_i_d[k]  = comb_in_i[k];
            dly_q_d[k]  = comb_in_q[k];
         end
      end
   end

   // ---------------- output FIFO and overflow flag ----------------
   always_comb begin
      wr_req  = stb_q[STAGES];
      wr_i    = scale(comb_i_q[STAGES-1]);
      wr_q    = scale(comb_q_q[STAGES-1]);
      pop     = DATA_ACK && (count_q != '0);
      full    = (count_q == CNT_FULL);
      wr_en   = wr_req && (!full || pop);
      ovf_evt = wr_req && full && !pop;
      // The new pair becomes the head when nothing older survives this edge.
      land_at_head = wr_en && ((count_q == '0) || ((count_q == CNT_ONE) && pop));

      fifo_i_d = fifo_i_q;
      fifo_q_d = fifo_q_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         fifo_i_d[wr_ptr_q] = wr_i;
         fifo_q_d[wr_ptr_q] = wr_q;
         wr_ptr_d           = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      out_i_d = out_i_q;
      out_q_d = out_q_q;
      if (land_at_head) begin
         out_i_d = wr_i;
         out_q_d = wr_q;
      end else if (count_d != '0) begin
         out_i_d = fifo_i_q[rd_ptr_d];
         out_q_d = fifo_q_q[rd_ptr_d];
      end

      ovf_d = ovf_evt | (ovf_q & ~OVF_CLR);
   end

   always_ff @(posedge CIC_CLK) begin
      if (!RST_N) begin
         for (int k = 0; k < STAGES; k++) begin
            integ_i_q[k] <= '0;
            integ_q_q[k] <= '0;
            comb_i_q[k]  <= '0;
            comb_q_q[k]  <= '0;
            dly_i_q[k]   <= '0;
            dly_q_q[k]   <= '0;
         end
         cnt_q    <= '0;
         stb_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         out_i_q  <= '0;
         out_q_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         integ_i_q <= integ_i_d;
         integ_q_q <= integ_q_d;
         comb_i_q  <= comb_i_d;
         comb_q_q  <= comb_q_d;
         dly_i_q   <= dly_i_d;
         dly_q_q   <= dly_q_d;
         cnt_q     <= cnt_d;
         stb_q     <= stb_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         out_i_q   <= out_i_d;
         out_q_q   <= out_q_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: only entries behind a valid count are ever read.
   always_ff @(posedge CIC_CLK) begin
      fifo_i_q <= fifo_i_d;
      fifo_q_q <= fifo_q_d;
   end

   assign OUT_I    = out_i_q;
   assign OUT_Q    = out_q_q;
   assign DATA_RDY = (count_q != '0);
   assign OVF      = ovf_q;

endmodule

// File: tb/tb_cic_decim_iq.sv
// Randomised bench for cic_decim_iq: impulse-response reference model plus queue-based FIFO model.
module tb_cic_decim_iq;

   localparam int STAGES     = 3;
   localparam int DECIM      = 64;
   localparam int IN_W       = 12;
   localparam int OUT_W      = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int ACC_W      = IN_W + STAGES * $clog2(DECIM);
   localparam int HLEN       = STAGES * (DECIM - 1) + 1;
   localparam int LAT        = STAGES + 1;

   logic                    cic_clk = 1'b0;
   logic                    rst_n;
   logic signed [IN_W-1:0]  in_i, in_q;
   logic                    in_valid;
   logic signed [OUT_W-1:0] out_i, out_q;
   logic                    data_rdy, data_ack, ovf, ovf_clr;

   always #5 cic_clk = ~cic_clk;

   cic_decim_iq #(
      .STAGES(STAGES), .DECIM(DECIM), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .CIC_CLK(cic_clk), .RST_N(rst_n), .IN_I(in_i), .IN_Q(in_q), .IN_VALID(in_valid),
      .OUT_I(out_i), .OUT_Q(out_q), .DATA_RDY(data_rdy), .DATA_ACK(data_ack),
      .OVF(ovf), .OVF_CLR(ovf_clr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int     due;
      longint vi;
      longint vq;
   } pend_t;

   longint h [HLEN];
   longint xi_hist[$], xq_hist[$];
   pend_t  pend[$];
   longint fq_i[$], fq_q[$];
   longint last_i, last_q;
   bit     m_ovf;
   int     m_cnt;
   int     cyc;

   longint obs_i[$], obs_q[$];
   int     rise_q[$];
   int     first_rdy_cyc;
   bit     prev_rdy;

   // Overall response: STAGES cascaded length-DECIM boxcars.
   function automatic void build_h();
      longint tmp [HLEN];
      int     len;
      foreach (h[k]) h[k] = 0;
      h[0] = 1;
      len  = 1;
      for (int s = 0; s < STAGES; s++) begin
         foreach (tmp[k]) tmp[k] = 0;
         for (int a = 0; a < len; a++)
            for (int b = 0; b < DECIM; b++)
               tmp[a+b] += h[a];
         len += DECIM - 1;
         h = tmp;
      end
   endfunction

   // Output for the strobe at the newest sample; the integrator cascade adds STAGES-1 samples of delay.
   function automatic longint cic_ref(input bit q_ch);
      longint acc;
      int     n;
      int     idx;
      acc = 0;
      n   = xi_hist.size() - 1;
      for (int j = 0; j < HLEN; j++) begin
         idx = n - (STAGES - 1) - j;
         if (idx >= 0) acc += h[j] * (q_ch ? xq_hist[idx] : xi_hist[idx]);
      end
      return acc >>> (ACC_W - OUT_W);
   endfunction

   function automatic void model_clear();
      xi_hist.delete(); xq_hist.delete();
      pend.delete(); fq_i.delete(); fq_q.delete();
      last_i = 0; last_q = 0; m_ovf = 0; m_cnt = 0;
   endfunction

   task automatic tick();
      bit    pop, ovf_ev;
      pend_t p;
      @(posedge cic_clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         pop    = data_ack && (fq_i.size() > 0);
         ovf_ev = 0;
         if (pop) begin
            void'(fq_i.pop_front());
            void'(fq_q.pop_front());
         end
         if (pend.size() > 0) begin
            if (pend[0].due == cyc) begin
               p = pend.pop_front();
               if (fq_i.size() < FIFO_DEPTH) begin
                  fq_i.push_back(p.vi);
                  fq_q.push_back(p.vq);
               end else begin
                  ovf_ev = 1;
               end
            end
         end
         m_ovf = (m_ovf && !ovf_clr) || ovf_ev;
         if (in_valid) begin
            xi_hist.push_back(longint'(in_i));
            xq_hist.push_back(longint'(in_q));
            if (m_cnt == DECIM - 1) begin
               p.due = cyc + LAT;
               p.vi  = cic_ref(1'b0);
               p.vq  = cic_ref(1'b1);
               pend.push_back(p);
            end
            m_cnt = (m_cnt + 1) % DECIM;
         end
         if (fq_i.size() > 0) begin
            last_i = fq_i[0];
            last_q = fq_q[0];
         end
      end
      cyc++;
      #1;
      check("data_rdy", data_rdy, fq_i.size() > 0);
      check("ovf", ovf, m_ovf);
      check("out_i", out_i, last_i);
      check("out_q", out_q, last_q);
      if (data_rdy && !prev_rdy) rise_q.push_back(cyc - 1);
      if (data_rdy && first_rdy_cyc < 0) first_rdy_cyc = cyc - 1;
      prev_rdy = data_rdy;
   endtask

   // vmode: 0 every cycle, 1 every 3rd, 2 random, 3 none
   // amode: 0 never, 1 always, 2 frequent random, 3 on write edges only, 4 rare random
   task automatic run(input int ncyc, input int vmode, input int dmode,
                      input int ci, input int cq, input int amode);
      for (int k = 0; k < ncyc; k++) begin
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = (k % 3 == 0);
            2:       in_valid = 1'($urandom_range(0, 1));
            default: in_valid = 1'b0;
         endcase
         if (dmode == 0) begin
            in_i = IN_W'(ci);
            in_q = IN_W'(cq);
         end else begin
            in_i = IN_W'($urandom);
            in_q = IN_W'($urandom);
         end
         data_ack = 1'b0;
         case (amode)
            1: data_ack = 1'b1;
            2: data_ack = ($urandom_range(0, 3) == 0);
            3: if (pend.size() > 0) data_ack = (pend[0].due == cyc);
            4: data_ack = ($urandom_range(0, 199) == 0);
            default: data_ack = 1'b0;
         endcase
         if (amode == 2 || amode == 4) ovf_clr = ($urandom_range(0, 31) == 0);
         if (data_ack && data_rdy) begin
            obs_i.push_back(longint'(out_i));
            obs_q.push_back(longint'(out_q));
         end
         tick();
      end
   endtask

   initial begin
      int first_valid;
      int bound;
      int n_before;

      build_h();
      model_clear();
      cyc = 0; first_rdy_cyc = -1; prev_rdy = 0;
      rst_n = 1'b0; in_i = '0; in_q = '0; in_valid = 1'b0; data_ack = 1'b0; ovf_clr = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_out_i", out_i, 0);
      check("rst_out_q", out_q, 0);
      check("rst_rdy", data_rdy, 0);
      check("rst_ovf", ovf, 0);

      // Constant 2 on both channels, consumer always ready
      first_valid = cyc; first_rdy_cyc = -1;
      obs_i.delete(); obs_q.delete();
      run(DECIM * 8, 0, 0, 2, 2, 1);
      check("first_rdy_latency", first_rdy_cyc - first_valid, 63 + 4);
      if (obs_i.size() >= 5) begin
         check("const2_i_4th", obs_i[3], 32);
         check("const2_q_4th", obs_q[3], 32);
         check("const2_i_last", obs_i[obs_i.size()-1], 32);
      end else check("const2_count", obs_i.size(), 5);

      // Full-scale extremes
      obs_i.delete(); obs_q.delete();
      run(DECIM * 8, 0, 0, 2047, -2048, 1);
      if (obs_i.size() >= 1) begin
         check("max_i", obs_i[obs_i.size()-1], 32752);
         check("min_q", obs_q[obs_q.size()-1], -32768);
      end else check("extreme_count", obs_i.size(), 1);

      // Valid every third cycle
      obs_i.delete(); obs_q.delete(); rise_q.delete();
      run(DECIM * 3 * 7, 1, 0, 2, 2, 1);
      if (rise_q.size() >= 2) begin
         check("spacing", rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2], 192);
         check("slow_i", obs_i[obs_i.size()-1], 32);
      end else check("slow_count", rise_q.size(), 2);

      // Overflow: fill with no consumer
      run(10, 3, 0, 2, 2, 1);
      run(DECIM * 6, 0, 0, 2, 2, 0);
      check("ovf_set", ovf, 1);
      check("full_rdy", data_rdy, 1);
      run(8, 3, 0, 2, 2, 0);
      ovf_clr = 1'b1;
      run(1, 3, 0, 2, 2, 0);
      ovf_clr = 1'b0;
      check("ovf_cleared", ovf, 0);

      // Full FIFO with pop coincident with each write
      run(DECIM * 2, 0, 0, 2, 2, 3);
      run(8, 3, 0, 2, 2, 3);
      check("ovf_coincident", ovf, 0);
      n_before = obs_i.size();
      run(8, 3, 0, 2, 2, 1);
      check("drain_count", obs_i.size() - n_before, FIFO_DEPTH);
      run(5, 3, 0, 2, 2, 1);
      check("empty_ack_rdy", data_rdy, 0);

      // Random traffic
      run(2500, 2, 1, 0, 0, 2);
      run(2500, 2, 1, 0, 0, 4);
      ovf_clr = 1'b0;

      // Reset two edges after a strobe
      run(12, 3, 0, 2, 2, 1);
      ovf_clr = 1'b1;
      run(1, 3, 0, 2, 2, 1);
      ovf_clr = 1'b0;
      bound = 0;
      while (pend.size() == 0 && bound < 2 * DECIM) begin
         run(1, 0, 0, 2, 2, 1);
         bound++;
      end
      check("strobe_seen", pend.size() > 0, 1);
      run(1, 0, 0, 2, 2, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_rdy", data_rdy, 0);
      check("midrst_out_i", out_i, 0);
      check("midrst_out_q", out_q, 0);
      first_valid = cyc; first_rdy_cyc = -1;
      run(DECIM * 2, 0, 0, 2, 2, 1);
      check("post_rst_latency", first_rdy_cyc - first_valid, 63 + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cic_decim_iq.md
Name: cic_decim_iq

Overview:
- Parametrised two-channel (I/Q) CIC decimator that succeeds the single-channel fixed-width decimator inside ddc.
- Sits between the NCO/mixer outputs and the MCU readout path.
- Adds configurable stages, decimation ratio and widths, a small output FIFO, and an overflow flag.
- Keeps the existing DATA_RDY/DATA_ACK readout handshake.

Parameters:
- STAGES, 3: number of integrator/comb stages N (1..6).
- DECIM, 64: decimation ratio R, power of two, DECIM >= STAGES+2.
- IN_W, 12: signed input sample width per channel.
- OUT_W, 16: signed output width per channel.
- FIFO_DEPTH, 4: output FIFO depth in I/Q pairs, power of two, >= 2.
- Derived ACC_W = IN_W + STAGES*log2(DECIM) (30 at defaults).

Ports:
- CIC_CLK  in  1  sole clock. All logic on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IN_I  in  IN_W  signed I sample.
- IN_Q  in  IN_W  signed Q sample.
- IN_VALID  in  1  sample strobe. Samples are taken at edges where it is high; may be high every cycle.
- OUT_I  out  OUT_W  signed I output, the FIFO head.
- OUT_Q  out  OUT_W  signed Q output, the FIFO head.
- DATA_RDY  out  1  FIFO not empty.
- DATA_ACK  in  1  consumer pops the head.
- OVF  out  1  sticky overflow flag.
- OVF_CLR  in  1  clears OVF.

Behaviour:
- Reset (RST_N low at an edge): clear integrators, combs, delay registers, decimation counter and FIFO pointers/count.
  - Outputs after reset: OUT_I=0, OUT_Q=0, DATA_RDY=0, OVF=0.
  - Reset mid-operation discards all pending data, including comb pipeline contents.
- Integrators:
  - Each channel has STAGES cascaded ACC_W-bit integrators.
  - Input is sign-extended to ACC_W.
  - Integrators update only on IN_VALID edges.
  - Two's-complement wrap-around is intended; no saturation.
- Decimation counter:
  - Range 0..DECIM-1, advances on IN_VALID.
  - The edge where IN_VALID=1 and count=DECIM-1 is strobe edge 0; the counter wraps to 0 at that edge.
- Comb pipeline:
  - Edge 1 captures the last-integrator value produced at edge 0.
  - Comb stage k registers at edge k, k=1..STAGES: y = x - x_prev (ACC_W, wrapping).
  - x_prev updates only on strobes.
  - The pipeline never stalls.
- Output scaling:
  - result = comb output bits [ACC_W-1 : ACC_W-OUT_W].
  - Truncation toward negative infinity; no rounding.
- FIFO write:
  - The I/Q pair is written at edge STAGES+1.
  - DATA_RDY is high after that edge (latency STAGES+1 cycles from strobe edge 0).
  - DATA_RDY stays high while the FIFO is non-empty.
- Handshake:
  - DATA_ACK=1 at an edge with DATA_RDY=1 pops one pair.
  - OUT_I/OUT_Q present the new head, or hold the last value if the FIFO becomes empty, after that edge.
  - DATA_ACK with DATA_RDY=0 is ignored.
  - A consumer holding DATA_ACK high drains one pair per cycle.
- Full FIFO:
  - A write to a full FIFO without a same-edge pop drops the new pair.
  - That write sets OVF; FIFO contents are unchanged.
  - Full plus write plus pop at the same edge: both occur, no OVF.
  - Empty plus write plus ACK: ACK is ignored, the write lands.
- OVF_CLR:
  - OVF_CLR=1 clears OVF.
  - If an overflow event and OVF_CLR occur at the same edge, set wins.
- Pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset then IN_I=IN_Q=2 constant, IN_VALID every cycle, ACK every RDY (defaults) -> outputs 4th onward exactly 32 on both channels (2*64^3>>14); first RDY at cycle 63+4 after first valid.
- IN_I=+2047, IN_Q=-2048 constant -> settled OUT_I=32752, OUT_Q=-32768; no wrap artefacts.
- IN_VALID every 3rd cycle, IN=2 -> output pairs spaced 192 cycles; steady value still 32.
- DATA_ACK held 0 for 6 decimation periods -> 4 pairs stored, OVF=1 after 5th; then ACK drains exactly 4 pairs in order; OVF_CLR -> OVF=0.
- FIFO full, ACK coincident with write edge -> no OVF, count stays 4; ACK while empty -> no change.
- RST_N low for 1 cycle mid-pipeline (edge 2 after strobe) -> DATA_RDY=0, outputs 0, no stale pair ever emitted; next output 64 valid samples later.
